// File: rtl/fifo_link_pkg.sv
// rtl/fifo_link_pkg.sv - shared types and helpers for the credit-based FIFO link
//
// Purpose: link FSM state encoding and the credit counter width helper used by
//          fifo_credit_tx and fifo_credit_ctr.
// Ports:   none (package).
package fifo_link_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } link_state_t;

  // The credit count spans 0..2**idx inclusive, so it needs one more bit than the slot index.
  function automatic int credit_width(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/fifo_credit_ctr.sv
// rtl/fifo_credit_ctr.sv - saturating up/down credit counter with sticky overflow flag
//
// Purpose: holds the number of free remote FIFO slots. Resets to full (2**IDX).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_dec         one credit consumed this cycle (a beat was sent)
//   i_inc         one credit returned this cycle (remote pop)
//   o_count       current credit count, 0..2**IDX
//   o_overflow    sticky: a return arrived while already full
module fifo_credit_ctr
  import fifo_link_pkg::*;
#(
  parameter int IDX = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_dec,
  input  logic                        i_inc,
  output logic [credit_width(IDX)-1:0] o_count,
  output logic                        o_overflow
);

  localparam int                CW     = credit_width(IDX);
  localparam logic [CW-1:0]     LP_MAX = CW'(2 ** IDX);

  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [CW-1:0] w_next;
  logic          w_ovf;

  // Simultaneous inc and dec cancel. Both ends saturate; only the top end is an error,
  // since the bottom end is unreachable while the sender respects in_rdy.
  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_count == LP_MAX) w_ovf = 1'b1;
      else                   w_next = r_count + CW'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count != '0)     w_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= LP_MAX;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_next;
      r_overflow <= r_overflow | w_ovf;
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/fifo_credit_tx.sv
// rtl/fifo_credit_tx.sv - transmit end of a credit-based link into a remote receive FIFO
//
// Purpose: accepts a val/rdy stream, forwards each beat one cycle later with its remote
//          slot index, and only sends while credits (free remote slots) remain. A flush
//          request stops intake and pulses flush_done once every credit is back.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_val/in_rdy  upstream handshake, in_data upstream data
//   out_val        registered beat valid, out_data beat data, out_seq remote slot index
//   credit_ret     one credit returned this cycle
//   flush_req      pulse: stop accepting and wait for all credits
//   flush_done     one-cycle pulse when the link is drained
//   credits        current credit count
//   err_overflow   sticky: credit returned while already full
module fifo_credit_tx
  import fifo_link_pkg::*;
#(
  parameter int INFLIGHT_IDX = 2,
  parameter int SIZE         = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_val,
  output logic                                 in_rdy,
  input  logic [SIZE-1:0]                      in_data,
  output logic                                 out_val,
  output logic [SIZE-1:0]                      out_data,
  output logic [INFLIGHT_IDX-1:0]              out_seq,
  input  logic                                 credit_ret,
  input  logic                                 flush_req,
  output logic                                 flush_done,
  output logic [credit_width(INFLIGHT_IDX)-1:0] credits,
  output logic                                 err_overflow
);

  localparam int            CW     = credit_width(INFLIGHT_IDX);
  localparam logic [CW-1:0] LP_MAX = CW'(2 ** INFLIGHT_IDX);

  link_state_t             r_state;
  link_state_t             w_state_next;
  logic                    r_out_val;
  logic [SIZE-1:0]         r_out_data;
  logic [INFLIGHT_IDX-1:0] r_out_seq;
  logic [INFLIGHT_IDX-1:0] r_seq_ctr;
  logic                    w_send;
  logic                    w_rdy;

  // flush_req blocks a send in its own cycle, so it feeds in_rdy directly; in_val never does.
  assign w_rdy  = (r_state == RUN) && (credits != '0) && !flush_req;
  assign w_send = in_val && w_rdy;

  fifo_credit_ctr #(
    .IDX (INFLIGHT_IDX)
  ) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_dec      (w_send),
    .i_inc      (credit_ret),
    .o_count    (credits),
    .o_overflow (err_overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // Drained means every remote slot is free and no beat is still on the wire.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (flush_req) w_state_next = DRAIN;
      DRAIN:   if ((credits == LP_MAX) && !r_out_val) w_state_next = DONE;
      DONE:    w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // Sequence counter width equals the slot index, so it wraps mod INFLIGHT naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_val  <= 1'b0;
      r_out_data <= '0;
      r_out_seq  <= '0;
      r_seq_ctr  <= '0;
    end else begin
      r_out_val <= w_send;
      if (w_send) begin
        r_out_data <= in_data;
        r_out_seq  <= r_seq_ctr;
        r_seq_ctr  <= r_seq_ctr + 1'b1;
      end
    end
  end

  assign in_rdy     = w_rdy;
  assign out_val    = r_out_val;
  assign out_data   = r_out_data;
  assign out_seq    = r_out_seq;
  assign flush_done = (r_state == DONE);

endmodule
